// File: rtl/scan_cfg_pkg.sv
// rtl/scan_cfg_pkg.sv - shared types and constants for the scan chain loader
package scan_cfg_pkg;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } scan_state_e;

endpackage

// File: rtl/scan_chain_loader_if.sv
// rtl/scan_chain_loader_if.sv - configuration byte stream (valid/ready) between source and loader
interface scan_chain_loader_if;
    import scan_cfg_pkg::*;

    logic [BYTE_W-1:0] IN_DATA;
    logic              IN_VALID;
    logic              IN_READY;

    modport master (output IN_DATA, output IN_VALID, input IN_READY);
    modport slave  (input IN_DATA, input IN_VALID, output IN_READY);

endinterface

// File: rtl/scan_byte_shifter.sv
// rtl/scan_byte_shifter.sv - 8-bit parallel-load right shift register with bit countdown
module scan_byte_shifter
    import scan_cfg_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_load,
    input  logic [BYTE_W-1:0]    i_load_data,
    input  logic [BIT_CNT_W-1:0] i_load_cnt,
    input  logic                 i_shift,
    input  logic                 i_shift_in,
    output logic [BYTE_W-1:0]    o_data,
    output logic [BIT_CNT_W-1:0] o_cnt,
    output logic                 o_empty
);

    logic [BYTE_W-1:0]    r_data;
    logic [BIT_CNT_W-1:0] r_cnt;

    // Load wins over shift; shifting stops once the count reaches zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
            r_cnt  <= i_load_cnt;
        end else if (i_shift && (r_cnt != '0)) begin
            r_data <= {i_shift_in, r_data[BYTE_W-1:1]};
            r_cnt  <= r_cnt - BIT_CNT_W'(1);
        end
    end

    assign o_data  = r_data;
    assign o_cnt   = r_cnt;
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/scan_chain_loader.sv
// rtl/scan_chain_loader.sv - serializes config bytes LSB-first onto the scan chain; readback under SCAN_READBACK_EN
module scan_chain_loader
    import scan_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 64
)(
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    scan_chain_loader_if.slave in_if,
    output logic               CFG_SIN,
    output logic               CFG_CE,
    input  logic               CFG_SOUT,
    output logic               BUSY,
    output logic               DONE,
    output logic [BYTE_W-1:0]  RB_DATA,
    output logic               RB_VALID
);

    localparam int                CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0]  LEN_INIT = CNT_W'(CHAIN_LEN);

    scan_state_e          r_state, w_next;
    logic [CNT_W-1:0]     r_remain;
    logic                 r_ready, r_ce, r_busy, r_done;
    logic                 w_start_ok, w_accept;
    logic [BIT_CNT_W-1:0] w_k;
    logic [BYTE_W-1:0]    w_tx_data;
    logic [BIT_CNT_W-1:0] w_tx_cnt;
    logic                 w_tx_empty;
    logic                 w_unused;

    assign w_start_ok = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept   = r_ready && in_if.IN_VALID;
    assign w_k        = (int'(r_remain) >= BYTE_W) ? BIT_CNT_W'(BYTE_W) : BIT_CNT_W'(r_remain);

    // Next-state: leave SHIFT on the last bit of the current byte
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (START) w_next = ST_LOAD;
            ST_LOAD:  if (w_accept) w_next = ST_SHIFT;
            ST_SHIFT: if (w_tx_cnt == BIT_CNT_W'(1))
                          w_next = (r_remain == CNT_W'(1)) ? ST_DONE : ST_LOAD;
            ST_DONE:  if (START) w_next = ST_LOAD;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State, registered outputs decoded from next state, and chain bit countdown
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
            r_ready  <= 1'b0;
            r_ce     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ready  <= (w_next == ST_LOAD);
            r_ce     <= (w_next == ST_SHIFT);
            r_busy   <= (w_next == ST_LOAD) || (w_next == ST_SHIFT);
            r_done   <= (w_next == ST_DONE);
            if (w_start_ok)
                r_remain <= LEN_INIT;
            else if ((r_state == ST_SHIFT) && (r_remain != '0))
                r_remain <= r_remain - CNT_W'(1);
        end
    end

    scan_byte_shifter u_tx (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_load      (w_accept),
        .i_load_data (in_if.IN_DATA),
        .i_load_cnt  (w_k),
        .i_shift     (r_state == ST_SHIFT),
        .i_shift_in  (1'b0),
        .o_data      (w_tx_data),
        .o_cnt       (w_tx_cnt),
        .o_empty     (w_tx_empty)
    );

    assign in_if.IN_READY = r_ready;
    assign CFG_SIN        = w_tx_data[0];
    assign CFG_CE         = r_ce;
    assign BUSY           = r_busy;
    assign DONE           = r_done;

`ifdef SCAN_READBACK_EN
    logic [BYTE_W-1:0]    w_rb_data, w_rb_shifted, r_rb_data;
    logic [BIT_CNT_W-1:0] w_rb_cnt;
    logic                 w_rb_empty, w_rb_emit, r_rb_valid;

    // A group closes after 8 samples or on the final chain bit; partial groups are right-aligned
    assign w_rb_shifted = {CFG_SOUT, w_rb_data[BYTE_W-1:1]};
    assign w_rb_emit    = r_ce && ((w_rb_cnt == BIT_CNT_W'(1)) || (r_remain == CNT_W'(1)));

    scan_byte_shifter u_rb (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_load      (w_start_ok || w_rb_emit),
        .i_load_data ('0),
        .i_load_cnt  (BIT_CNT_W'(BYTE_W)),
        .i_shift     (r_ce),
        .i_shift_in  (CFG_SOUT),
        .o_data      (w_rb_data),
        .o_cnt       (w_rb_cnt),
        .o_empty     (w_rb_empty)
    );

    // Readback byte register and one-cycle strobe
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= w_rb_emit;
            if (w_rb_emit)
                r_rb_data <= w_rb_shifted >> (w_rb_cnt - BIT_CNT_W'(1));
        end
    end

    assign RB_DATA  = r_rb_data;
    assign RB_VALID = r_rb_valid;
    assign w_unused = &{1'b0, w_tx_empty, w_tx_data[BYTE_W-1:1], w_rb_empty, w_rb_data[0]};
`else
    assign RB_DATA  = '0;
    assign RB_VALID = 1'b0;
    assign w_unused = &{1'b0, w_tx_empty, w_tx_data[BYTE_W-1:1], CFG_SOUT};
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// tb/tb_scan_chain_loader.sv - directed vector bench for scan_chain_loader (16- and 13-bit chains)
module tb_scan_chain_loader;
    import scan_cfg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_a, start_b, sel;
    logic [7:0] tb_data;
    logic       tb_valid;
    logic       sin_a, ce_a, busy_a, done_a, rbv_a, sout_a;
    logic       sin_b, ce_b, busy_b, done_b, rbv_b, sout_b;
    logic [7:0] rbd_a, rbd_b;
    logic [15:0] chain_a = '0;
    logic [12:0] chain_b = '0;

    int n_vec = 0;
    int n_err = 0;
    int h_nce, h_idx, h_cyc;

    scan_chain_loader_if if_a();
    scan_chain_loader_if if_b();
    assign if_a.IN_DATA  = tb_data;
    assign if_a.IN_VALID = tb_valid;
    assign if_b.IN_DATA  = tb_data;
    assign if_b.IN_VALID = tb_valid;

    scan_chain_loader #(.CHAIN_LEN(16)) dut_a (
        .CLK(clk), .RST(rst), .START(start_a), .in_if(if_a),
        .CFG_SIN(sin_a), .CFG_CE(ce_a), .CFG_SOUT(sout_a),
        .BUSY(busy_a), .DONE(done_a), .RB_DATA(rbd_a), .RB_VALID(rbv_a)
    );

    scan_chain_loader #(.CHAIN_LEN(13)) dut_b (
        .CLK(clk), .RST(rst), .START(start_b), .in_if(if_b),
        .CFG_SIN(sin_b), .CFG_CE(ce_b), .CFG_SOUT(sout_b),
        .BUSY(busy_b), .DONE(done_b), .RB_DATA(rbd_b), .RB_VALID(rbv_b)
    );

    // Downstream chain models: head takes SIN, tail drives SOUT
    always @(posedge clk) begin
        if (ce_a) chain_a <= {sin_a, chain_a[15:1]};
        if (ce_b) chain_b <= {sin_b, chain_b[12:1]};
    end
    assign sout_a = chain_a[0];
    assign sout_b = chain_b[0];

    logic       w_ce, w_sin, w_ready, w_busy, w_done, w_rbv;
    logic [7:0] w_rbd;
    assign w_ce    = sel ? ce_b : ce_a;
    assign w_sin   = sel ? sin_b : sin_a;
    assign w_ready = sel ? if_b.IN_READY : if_a.IN_READY;
    assign w_busy  = sel ? busy_b : busy_a;
    assign w_done  = sel ? done_b : done_a;
    assign w_rbv   = sel ? rbv_b : rbv_a;
    assign w_rbd   = sel ? rbd_b : rbd_a;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_seq;
        bit          gaps;
        bit          start_mid;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_load(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [15:0] exp_seq, input int len, input bit gaps,
                            input bit start_mid);
        logic [15:0] seq, rb, exp_rb;
        int nce, nrb, proto, cyc, idx;
        bit acc_pend, finished;
        seq = '0; rb = '0; nce = 0; nrb = 0; proto = 0; cyc = 0; idx = 0;
        acc_pend = 1'b0; finished = 1'b0;
        exp_rb = sel ? {3'b000, chain_b} : chain_a;
        @(negedge clk);
        tb_valid = 1'b0;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        while (!finished && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (cyc == 1) begin
                check({tag, " busy after start"}, 32'(w_busy), 32'd1);
                check({tag, " done clear after start"}, 32'(w_done), 32'd0);
            end
            if (w_ce) begin
                if (nce < 16) seq[nce] = w_sin;
                nce++;
                if (w_ready) proto++;
            end
            if (acc_pend && !w_ce) proto++;
            if (w_rbv) begin
                if (nrb < 2) rb[nrb*8 +: 8] = w_rbd;
                nrb++;
            end
            if (w_done) begin
                finished = 1'b1;
            end else begin
                if (start_mid && w_ce && nce == 3) begin
                    if (sel) start_b = 1'b1; else start_a = 1'b1;
                end
                tb_valid = gaps ? 1'($urandom_range(0, 1)) : (idx < 2);
                tb_data  = (idx == 0) ? b0 : ((idx == 1) ? b1 : 8'hEE);
                acc_pend = tb_valid && w_ready;
                if (acc_pend) idx++;
            end
        end
        tb_valid = 1'b0;
        check({tag, " done reached"}, 32'(finished), 32'd1);
        check({tag, " sin sequence"}, 32'(seq), 32'(exp_seq));
        check({tag, " ce count"}, 32'(nce), 32'(len));
        check({tag, " bytes consumed"}, 32'(idx), 32'd2);
        check({tag, " ce/ready overlap or accept latency"}, 32'(proto), 32'd0);
        check({tag, " chain model"}, sel ? 32'({3'b000, chain_b}) : 32'(chain_a), 32'(exp_seq));
`ifdef SCAN_READBACK_EN
        check({tag, " rb pulses"}, 32'(nrb), 32'd2);
        check({tag, " rb data"}, 32'(rb), 32'(exp_rb));
`else
        check({tag, " rb pulses"}, 32'(nrb), 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h12, 8'h34, 16'h3412, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h00, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{8'hA5, 8'h3C, 16'h3CA5, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'h00, 16'h00FF, 1'b1, 1'b1};
        vecs[4] = '{8'h81, 8'h7E, 16'h7E81, 1'b1, 1'b0};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        tb_valid = 1'b0; tb_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset ready", 32'(if_a.IN_READY), 32'd0);
        check("reset ce", 32'(ce_a), 32'd0);
        check("reset sin", 32'(sin_a), 32'd0);
        check("reset busy", 32'(busy_a), 32'd0);
        check("reset done", 32'(done_a), 32'd0);
        check("reset rb_valid", 32'(rbv_a), 32'd0);
        check("reset rb_data", 32'(rbd_a), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_load($sformatf("v%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].exp_seq,
                     16, vecs[i].gaps, vecs[i].start_mid);

        // Abort on the 5th CE cycle of byte 2
        @(negedge clk);
        start_a = 1'b1; tb_valid = 1'b1; tb_data = 8'hA5;
        h_nce = 0; h_idx = 0; h_cyc = 0;
        while (h_nce < 13 && h_cyc < 100) begin
            @(negedge clk);
            h_cyc++;
            start_a = 1'b0;
            if (ce_a) h_nce++;
            if (h_nce == 13 && ce_a) begin
                rst = 1'b1;
            end else begin
                tb_data = (h_idx == 0) ? 8'hA5 : 8'h3C;
                if (if_a.IN_READY) h_idx++;
            end
        end
        check("abort reached 13th ce", 32'(h_nce), 32'd13);
        @(negedge clk);
        check("abort ce", 32'(ce_a), 32'd0);
        check("abort busy", 32'(busy_a), 32'd0);
        check("abort done", 32'(done_a), 32'd0);
        check("abort ready", 32'(if_a.IN_READY), 32'd0);
        rst = 1'b0; tb_valid = 1'b0;

        // START and RST together: reset wins
        @(negedge clk);
        start_a = 1'b1; rst = 1'b1;
        @(negedge clk);
        start_a = 1'b0; rst = 1'b0;
        check("start+rst busy", 32'(busy_a), 32'd0);
        check("start+rst ready", 32'(if_a.IN_READY), 32'd0);
        @(negedge clk);
        check("idle stays idle ready", 32'(if_a.IN_READY), 32'd0);

        run_load("reload", 8'hA5, 8'h3C, 16'h3CA5, 16, 1'b0, 1'b0);

        sel = 1'b1;
        run_load("len13 a", 8'hFF, 8'h15, 16'h15FF, 13, 1'b0, 1'b0);
        run_load("len13 b", 8'h3C, 8'hEA, 16'h0A3C, 13, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
